// File: rtl/mod_reconstruct.sv
// Rebuilds a dividend from quotient, divisor and remainder (q*y + r) using a
// W-iteration shift-and-add datapath with a start/busy/done handshake.
module mod_reconstruct #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] q,
   input  logic [W-1:0] y,
   input  logic [W-1:0] r,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] out,
   output logic [W-1:0] out_hi,
   output logic         ovf,
   output logic         rem_err
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [2*W-1:0]   acc_q, acc_d;
   logic [2*W-1:0]   mcand_q, mcand_d;
   logic [W-1:0]     mreg_q, mreg_d;
   logic [CW-1:0]    count_q, count_d;
   logic             rem_lat_q, rem_lat_d;
   logic [W-1:0]     out_q, out_d;
   logic [W-1:0]     out_hi_q, out_hi_d;
   logic             ovf_q, ovf_d;
   logic             rem_err_q, rem_err_d;
   logic             done_q, done_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         mcand_q   <= '0;
         mreg_q    <= '0;
         count_q   <= '0;
         rem_lat_q <= 1'b0;
         out_q     <= '0;
         out_hi_q  <= '0;
         ovf_q     <= 1'b0;
         rem_err_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mreg_q    <= mreg_d;
         count_q   <= count_d;
         rem_lat_q <= rem_lat_d;
         out_q     <= out_d;
         out_hi_q  <= out_hi_d;
         ovf_q     <= ovf_d;
         rem_err_q <= rem_err_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mreg_d    = mreg_q;
      count_d   = count_q;
      rem_lat_d = rem_lat_q;
      out_d     = out_q;
      out_hi_d  = out_hi_q;
      ovf_d     = ovf_q;
      rem_err_d = rem_err_q;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               mreg_d    = q;
               mcand_d   = {{W{1'b0}}, y};
               acc_d     = {{W{1'b0}}, r};
               // A zero divisor is flagged upstream, so it never counts as a bad remainder.
               rem_lat_d = (y != '0) && (r >= y);
               count_d   = '0;
               state_d   = RUN;
            end
         end
         RUN: begin
            if (mreg_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d = mcand_q << 1;
            mreg_d  = mreg_q >> 1;
            count_d = count_q + 1'b1;
            // Always W iterations, even once the multiplier has run out of ones.
            if (count_q == CW'(W - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            out_d     = acc_q[W-1:0];
            out_hi_d  = acc_q[2*W-1:W];
            ovf_d     = |acc_q[2*W-1:W];
            rem_err_d = rem_lat_q;
            done_d    = 1'b1;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy    = (state_q != IDLE);
   assign done    = done_q;
   assign out     = out_q;
   assign out_hi  = out_hi_q;
   assign ovf     = ovf_q;
   assign rem_err = rem_err_q;

endmodule

// File: tb/tb_mod_reconstruct.sv
// Directed bench for mod_reconstruct: hand-computed q*y + r results, latency,
// busy window, start-ignore, back-to-back and asynchronous reset behaviour.
module tb_mod_reconstruct;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] q, y, r;
   logic        busy, done, ovf, rem_err;
   logic [15:0] out, out_hi;

   int total = 0;
   int bad   = 0;
   int lat, busy_n, nd, dk, d1, d2;
   logic seen_done;

   mod_reconstruct #(.W(16)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .q       (q),
      .y       (y),
      .r       (r),
      .busy    (busy),
      .done    (done),
      .out     (out),
      .out_hi  (out_hi),
      .ovf     (ovf),
      .rem_err (rem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Launch one op and return the number of edges from the accepting edge to done.
   task automatic run_op(input logic [15:0] qi, input logic [15:0] yi, input logic [15:0] ri,
                         output int lat_o, output int busy_o);
      @(negedge clk);
      q = qi; y = yi; r = ri; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat_o = 0;
      busy_o = 0;
      while (!done && lat_o < 40) begin
         if (busy) busy_o++;
         @(negedge clk);
         lat_o++;
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; q = '0; y = '0; r = '0;
      #2;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_out", 32'(out), 32'd0);
      check("rst_out_hi", 32'(out_hi), 32'd0);
      check("rst_flags", {30'd0, ovf, rem_err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic: 5*7+3 = 38
      run_op(16'd5, 16'd7, 16'd3, lat, busy_n);
      check("basic_latency", 32'(lat), 32'd17);
      check("basic_busy_cycles", 32'(busy_n), 32'd17);
      check("basic_busy_at_done", 32'(busy), 32'd0);
      check("basic_out", 32'(out), 32'h0026);
      check("basic_out_hi", 32'(out_hi), 32'h0000);
      check("basic_ovf", 32'(ovf), 32'd0);
      check("basic_rem_err", 32'(rem_err), 32'd0);
      @(negedge clk);
      check("basic_done_pulse", 32'(done), 32'd0);
      check("basic_out_hold", 32'(out), 32'h0026);

      // Max: 0xFFFF*0xFFFF + 0xFFFF = 0xFFFF0000
      run_op(16'hFFFF, 16'hFFFF, 16'hFFFF, lat, busy_n);
      check("max_latency", 32'(lat), 32'd17);
      check("max_out", 32'(out), 32'h0000);
      check("max_out_hi", 32'(out_hi), 32'hFFFF);
      check("max_ovf", 32'(ovf), 32'd1);
      check("max_rem_err", 32'(rem_err), 32'd1);

      // Zero divisor: result is r, no remainder error
      run_op(16'd100, 16'd0, 16'd9, lat, busy_n);
      check("zdiv_latency", 32'(lat), 32'd17);
      check("zdiv_out", 32'(out), 32'd9);
      check("zdiv_out_hi", 32'(out_hi), 32'd0);
      check("zdiv_ovf", 32'(ovf), 32'd0);
      check("zdiv_rem_err", 32'(rem_err), 32'd0);

      // Non-canonical remainder: 1*4+4 = 8
      run_op(16'd1, 16'd4, 16'd4, lat, busy_n);
      check("noncanon_out", 32'(out), 32'd8);
      check("noncanon_rem_err", 32'(rem_err), 32'd1);

      // Zero quotient: result is r
      run_op(16'd0, 16'd50, 16'd17, lat, busy_n);
      check("zq_latency", 32'(lat), 32'd17);
      check("zq_out", 32'(out), 32'd17);
      check("zq_rem_err", 32'(rem_err), 32'd0);

      // Start pulses at edges 5 and 17 must be ignored: 2*3+1 = 7
      @(negedge clk);
      q = 16'd2; y = 16'd3; r = 16'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nd = 0; dk = 0;
      for (int k = 1; k <= 30; k++) begin
         if (k == 5 || k == 17) begin
            start = 1'b1; q = 16'd9; y = 16'd9; r = 16'd0;
         end
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            nd++;
            dk = k;
         end
      end
      check("ignore_done_count", 32'(nd), 32'd1);
      check("ignore_done_edge", 32'(dk), 32'd17);
      check("ignore_out", 32'(out), 32'd7);
      check("ignore_idle", 32'(busy), 32'd0);

      // Start held high: back-to-back ops every 18 cycles, 2*2+1 = 5
      @(negedge clk);
      q = 16'd2; y = 16'd2; r = 16'd1; start = 1'b1;
      d1 = -1; d2 = -1;
      for (int k = 0; k <= 35; k++) begin
         @(negedge clk);
         if (done) begin
            if (d1 < 0) d1 = k;
            else if (d2 < 0) d2 = k;
         end
      end
      start = 1'b0;
      check("held_first_done", 32'(d1), 32'd17);
      check("held_second_done", 32'(d2), 32'd35);
      check("held_out", 32'(out), 32'd5);
      repeat (20) @(negedge clk);

      // Async reset in the middle of a run
      @(negedge clk);
      q = 16'd5; y = 16'd7; r = 16'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      check("pre_rst_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_out", 32'(out), 32'd0);
      check("arst_out_hi", 32'(out_hi), 32'd0);
      check("arst_flags", {30'd0, ovf, rem_err}, 32'd0);
      seen_done = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
         if (k == 2) rst_n = 1'b1;
      end
      check("arst_no_done", 32'(seen_done), 32'd0);
      run_op(16'd3, 16'd3, 16'd0, lat, busy_n);
      check("post_rst_latency", 32'(lat), 32'd17);
      check("post_rst_out", 32'(out), 32'd9);
      check("post_rst_rem_err", 32'(rem_err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mod_reconstruct.md
Name: mod_reconstruct

Overview:
- Sequential inverse of the calculator's modulus/divide path: rebuilds the dividend from a quotient, divisor and remainder, out = q*y + r.
- Uses a 16-iteration shift-and-add datapath.
- Used by the scientific calculator core to check divide/modulus results and to run the "multiply then add" key sequence without a combinational 16x16 multiplier.
- Start/busy/done handshake toward the calculator control FSM.

Parameters:
- W, 16, operand width of q, y, r and out; iteration count equals W.

Ports:
- clk  input  1  system clock, rising edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- q  input  16  quotient operand; latched on accepted start
- y  input  16  divisor operand; latched on accepted start
- r  input  16  remainder operand; latched on accepted start
- busy  output  1  high while in RUN or DONE
- done  output  1  one-cycle pulse; out/out_hi/ovf/rem_err valid
- out  output  16  low 16 bits of q*y + r
- out_hi  output  16  high 16 bits of q*y + r
- ovf  output  1  1 when q*y + r > 16'hFFFF (out_hi != 0)
- rem_err  output  1  1 when y != 0 and r >= y (remainder not canonical)

Behaviour:
- Reset (asynchronous, rst_n low, any state):
  - state = IDLE; busy, done, ovf and rem_err = 0; out and out_hi = 0.
  - Internal registers (accumulator, shifted multiplicand, multiplier, count) cleared.
  - Any operation in flight is abandoned, with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a rising edge: latch q into mreg, zero-extend y into a 32-bit mcand, load acc[31:0] = {16'h0, r}.
  - Same edge: compute rem_err = (y != 0) && (r >= y) and hold it internally; clear count to 0; go to RUN.
  - start=0: stay in IDLE; outputs hold their last values.
- RUN, each edge:
  - if mreg[0], acc <= acc + mcand;
  - then mcand <= mcand << 1, mreg <= mreg >> 1, count <= count + 1.
  - After the edge where count = W-1 is processed, go to DONE.
  - Exactly W RUN edges; no early termination when mreg becomes 0.
- DONE:
  - At entry: out = acc[15:0], out_hi = acc[31:16], ovf = |acc[31:16], rem_err = latched value, done = 1.
  - Next edge: done = 0, go to IDLE.
  - out, out_hi, ovf and rem_err then hold until the next result is registered.
- Latency:
  - Accepting edge E0; done high for the one cycle following edge E0+W+1 (17 edges for W=16).
  - Throughput is one operation per W+2 cycles.
- Handshake:
  - start is ignored in RUN and DONE; it is not queued.
  - Operand changes after the accepting edge have no effect.
  - busy = (state != IDLE).
- Arithmetic:
  - Accumulator is 32 bits, unsigned.
  - Maximum result 0xFFFF*0xFFFF + 0xFFFF = 0xFFFF0000 fits, so there is no carry loss.
  - All operands are unsigned.
- y = 0:
  - Result is r; rem_err = 0, since a divide-by-zero is flagged upstream.
  - The full W cycles are still taken.
- q = 0: result r, same latency.
- start held high continuously: a new op is accepted on the first edge in IDLE after each DONE.

Test Plan:
- Basic: q=5, y=7, r=3, start one cycle -> done exactly 17 edges after the accepting edge; out=38 (0x0026), out_hi=0, ovf=0, rem_err=0; busy high for 17 cycles.
- Max: q=y=r=16'hFFFF -> out=16'h0000, out_hi=16'hFFFF, ovf=1, rem_err=1 (r >= y).
- Zero divisor: q=100, y=0, r=9 -> out=9, ovf=0, rem_err=0.
- Non-canonical remainder: q=1, y=4, r=4 -> out=8, rem_err=1.
- Busy/ignore: start with q=2, y=3, r=1; pulse start with q=9, y=9, r=0 at edges 5 and 17 -> single done, out=7; the next op is accepted only in IDLE.
- Async reset at RUN edge 8, then release, then start with q=3, y=3, r=0:
  - During reset: busy=0, done=0, all outputs 0 immediately, no done pulse.
  - After release: done after 17 edges, out=9.
